// File: rtl/trace_arb_pkg.sv
// Shared constants and types for the trace stream arbiter.
// Holds the overflow bit position and the default record/counter widths.
package trace_arb_pkg;

    localparam int OVF_BIT    = 31;
    localparam int DEF_DATA_W = 128;
    localparam int DEF_CNT_W  = 16;

    // One holding entry at the default record width.
    typedef struct packed {
        logic                  full;
        logic                  ovf;
        logic [DEF_DATA_W-1:0] data;
    } hold_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first requester after last_grant_i, wrapping; the pointer lives in the parent.
module rr_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [SRC_W-1:0]   last_grant_i,
    output logic [NUM_SRC-1:0] grant_o,
    output logic [SRC_W-1:0]   grant_idx_o,
    output logic               any_grant_o
);

    logic [SRC_W-1:0] idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_grant_o = 1'b0;
        idx         = '0;
        // Offset 1..NUM_SRC visits every source once, ending on last_grant itself.
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = SRC_W'((int'(last_grant_i) + k) % NUM_SRC);
            if (!any_grant_o && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
                any_grant_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/trace_stream_arbiter.sv
// Merges NUM_SRC non-stallable trace streams onto one AXI-stream master.
// One holding register per source; overruns are dropped, counted and flagged on the next record.
module trace_stream_arbiter
    import trace_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [NUM_SRC-1:0]        s_axis_tvalid,
    output logic [NUM_SRC-1:0]        s_axis_tready,
    input  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [DATA_W-1:0]         m_axis_tdata,
    output logic [SRC_W-1:0]          m_axis_tdest,
    output logic [NUM_SRC*CNT_W-1:0]  drop_count,
    input  logic                      clear_counts
);

    logic                 out_free;
    logic [NUM_SRC-1:0]   full_vec;
    logic [NUM_SRC-1:0]   ovf_vec;
    logic [NUM_SRC-1:0]   grant_oh;
    logic [NUM_SRC-1:0]   drain;
    logic [DATA_W-1:0]    hold_data [NUM_SRC];
    logic [SRC_W-1:0]     grant_idx;
    logic                 any_grant;

    logic                 tvalid_q;
    logic [DATA_W-1:0]    tdata_q;
    logic [DATA_W-1:0]    tdata_d;
    logic [SRC_W-1:0]     tdest_q;
    logic [SRC_W-1:0]     last_grant_q;

    assign s_axis_tready = '1;
    assign out_free      = !tvalid_q || m_axis_tready;
    assign drain         = grant_oh & {NUM_SRC{out_free}};

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_rr (
        .req_i        (full_vec),
        .last_grant_i (last_grant_q),
        .grant_o      (grant_oh),
        .grant_idx_o  (grant_idx),
        .any_grant_o  (any_grant)
    );

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        logic              full_q, full_d;
        logic              ovf_q, ovf_d;
        logic              pend_q, pend_d;
        logic              capture, drop;
        logic [DATA_W-1:0] data_q, data_d;
        logic [CNT_W-1:0]  cnt_q, cnt_d;

        // Draining frees the slot in the same cycle, so a full-rate single source never drops.
        assign capture = s_axis_tvalid[gi] && (!full_q || drain[gi]);
        assign drop    = s_axis_tvalid[gi] && full_q && !drain[gi];

        always_comb begin
            full_d = full_q;
            ovf_d  = ovf_q;
            pend_d = pend_q;
            data_d = data_q;
            cnt_d  = cnt_q;
            if (capture) begin
                full_d = 1'b1;
                ovf_d  = pend_q;
                pend_d = 1'b0;
                data_d = s_axis_tdata[gi*DATA_W +: DATA_W];
            end else if (drain[gi]) begin
                full_d = 1'b0;
            end
            if (drop) begin
                pend_d = 1'b1;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            if (clear_counts) begin
                cnt_d = '0;
            end
        end

        always_ff @(posedge aclk) begin
            if (!aresetn) begin
                full_q <= 1'b0;
                ovf_q  <= 1'b0;
                pend_q <= 1'b0;
                data_q <= '0;
                cnt_q  <= '0;
            end else begin
                full_q <= full_d;
                ovf_q  <= ovf_d;
                pend_q <= pend_d;
                data_q <= data_d;
                cnt_q  <= cnt_d;
            end
        end

        assign full_vec[gi]                    = full_q;
        assign ovf_vec[gi]                     = ovf_q;
        assign hold_data[gi]                   = data_q;
        assign drop_count[gi*CNT_W +: CNT_W]   = cnt_q;
    end

    always_comb begin
        tdata_d          = hold_data[grant_idx];
        tdata_d[OVF_BIT] = tdata_d[OVF_BIT] | ovf_vec[grant_idx];
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            tvalid_q     <= 1'b0;
            tdata_q      <= '0;
            tdest_q      <= '0;
            last_grant_q <= SRC_W'(NUM_SRC - 1);
        end else if (out_free) begin
            if (any_grant) begin
                tvalid_q     <= 1'b1;
                tdata_q      <= tdata_d;
                tdest_q      <= grant_idx;
                last_grant_q <= grant_idx;
            end else begin
                tvalid_q <= 1'b0;
            end
        end
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tdest  = tdest_q;

endmodule

// File: tb/tb_trace_stream_arbiter.sv
// Directed bench for trace_stream_arbiter (4 sources, 128-bit records, 4-bit drop counters).
module tb_trace_stream_arbiter;

    localparam int NUM_SRC = 4;
    localparam int DATA_W  = 128;
    localparam int CNT_W   = 4;
    localparam int SRC_W   = 2;

    logic                      aclk = 1'b0;
    logic                      aresetn;
    logic [NUM_SRC-1:0]        s_axis_tvalid;
    logic [NUM_SRC-1:0]        s_axis_tready;
    logic [NUM_SRC*DATA_W-1:0] s_axis_tdata;
    logic                      m_axis_tvalid;
    logic                      m_axis_tready;
    logic [DATA_W-1:0]         m_axis_tdata;
    logic [SRC_W-1:0]          m_axis_tdest;
    logic [NUM_SRC*CNT_W-1:0]  drop_count;
    logic                      clear_counts;

    int total = 0;
    int bad   = 0;

    logic [127:0] ovf_m;
    logic         prev_stall;
    logic [127:0] prev_data;
    logic [1:0]   prev_dest;
    int           last_seq [NUM_SRC];
    int           accepted;

    always #5 aclk = ~aclk;

    trace_stream_arbiter #(
        .NUM_SRC (NUM_SRC),
        .DATA_W  (DATA_W),
        .CNT_W   (CNT_W),
        .SRC_W   (SRC_W)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tdest  (m_axis_tdest),
        .drop_count    (drop_count),
        .clear_counts  (clear_counts)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    function automatic logic [127:0] mk(input int s, input int n);
        return {64'(s), 64'(n)};
    endfunction

    function automatic int dc(input int s);
        return int'(drop_count[s*CNT_W +: CNT_W]);
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_data(input int s, input logic [127:0] v);
        s_axis_tdata[s*DATA_W +: DATA_W] = v;
    endtask

    // Observes the current cycle before its closing edge: stall stability and accepted records.
    task automatic sample_cycle();
        if (prev_stall) begin
            chk("stall_data", m_axis_tdata, prev_data);
            chk("stall_dest", 128'(m_axis_tdest), 128'(prev_dest));
        end
        if (m_axis_tvalid && m_axis_tready) begin
            accepted++;
            chk("src_tag", m_axis_tdata[127:64], 128'(m_axis_tdest));
            chk("seq_order", 128'(int'(m_axis_tdata[30:0]) > last_seq[m_axis_tdest]), 128'(1));
            last_seq[m_axis_tdest] = int'(m_axis_tdata[30:0]);
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_dest  = m_axis_tdest;
    endtask

    initial begin
        ovf_m         = 128'h1 << 31;
        aresetn       = 1'b0;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b0;
        clear_counts  = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
        chk("rst_tdata", m_axis_tdata, 128'(0));
        chk("rst_tdest", 128'(m_axis_tdest), 128'(0));
        chk("rst_drops", 128'(drop_count), 128'(0));
        chk("rst_tready", 128'(s_axis_tready), 128'hF);
        aresetn = 1'b1;
        tick();

        // Single record latency: valid in t, output valid in t+2
        m_axis_tready = 1'b1;
        s_axis_tvalid = 4'b0001;
        set_data(0, mk(0, 1));
        tick();
        s_axis_tvalid = '0;
        chk("lat_t1_idle", 128'(m_axis_tvalid), 128'(0));
        tick();
        chk("lat_t2_valid", 128'(m_axis_tvalid), 128'(1));
        chk("lat_t2_data", m_axis_tdata, mk(0, 1));
        chk("lat_t2_dest", 128'(m_axis_tdest), 128'(0));
        tick();
        chk("lat_t3_empty", 128'(m_axis_tvalid), 128'(0));

        // Overflow: output occupied by source 0, source 1 sends three records
        m_axis_tready = 1'b0;
        s_axis_tvalid = 4'b0001;
        set_data(0, mk(0, 2));
        tick();
        s_axis_tvalid = '0;
        tick();
        s_axis_tvalid = 4'b0010;
        for (int n = 1; n <= 3; n++) begin
            set_data(1, mk(1, n));
            tick();
        end
        s_axis_tvalid = '0;
        chk("ovf_drops1", 128'(dc(1)), 128'(2));
        chk("ovf_hold_data", m_axis_tdata, mk(0, 2));
        m_axis_tready = 1'b1;
        tick();
        chk("ovf_rec1_dest", 128'(m_axis_tdest), 128'(1));
        chk("ovf_rec1_clean", m_axis_tdata, mk(1, 1));
        s_axis_tvalid = 4'b0010;
        set_data(1, mk(1, 4));
        tick();
        s_axis_tvalid = '0;
        tick();
        chk("ovf_flagged", m_axis_tdata, mk(1, 4) | ovf_m);
        s_axis_tvalid = 4'b0010;
        set_data(1, mk(1, 5));
        tick();
        s_axis_tvalid = '0;
        tick();
        chk("ovf_after_clean", m_axis_tdata, mk(1, 5));
        repeat (3) tick();

        // tready toggling with sources 0 and 3 at full rate
        clear_counts = 1'b1;
        tick();
        clear_counts = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_dest  = '0;
        accepted   = 0;
        for (int s = 0; s < NUM_SRC; s++) last_seq[s] = -1;
        for (int i = 0; i < 12; i++) begin
            m_axis_tready = (i % 2 == 0);
            s_axis_tvalid = 4'b1001;
            set_data(0, mk(0, 100 + i));
            set_data(3, mk(3, 100 + i));
            sample_cycle();
            tick();
        end
        s_axis_tvalid = '0;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sample_cycle();
            tick();
        end
        chk("toggle_conserve", 128'(accepted + dc(0) + dc(3)), 128'(24));

        // Counter saturation on source 2 (4-bit counters)
        clear_counts = 1'b1;
        tick();
        clear_counts  = 1'b0;
        m_axis_tready = 1'b0;
        s_axis_tvalid = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            set_data(2, mk(2, 200 + i));
            tick();
        end
        chk("sat_drops3", 128'(dc(2)), 128'(3));
        for (int i = 0; i < 20; i++) tick();
        chk("sat_max", 128'(dc(2)), 128'(15));
        clear_counts = 1'b1;
        tick();
        clear_counts = 1'b0;
        chk("clear_wins", 128'(dc(2)), 128'(0));
        tick();
        chk("count_after_clear", 128'(dc(2)), 128'(1));

        // Reset while holding registers and output are full
        s_axis_tvalid = 4'b1111;
        for (int s = 0; s < NUM_SRC; s++) set_data(s, mk(s, 250));
        tick();
        s_axis_tvalid = '0;
        chk("pre_rst_valid", 128'(m_axis_tvalid), 128'(1));
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        chk("midrst_tvalid", 128'(m_axis_tvalid), 128'(0));
        chk("midrst_drops", 128'(drop_count), 128'(0));
        m_axis_tready = 1'b1;
        tick();
        chk("midrst_holds_clear", 128'(m_axis_tvalid), 128'(0));

        // All four sources at once: two rounds in order 0,1,2,3
        for (int r = 0; r < 2; r++) begin
            s_axis_tvalid = 4'b1111;
            for (int s = 0; s < NUM_SRC; s++) set_data(s, mk(s, 300 + r));
            tick();
            s_axis_tvalid = '0;
            for (int s = 0; s < NUM_SRC; s++) begin
                tick();
                chk("rr_dest", 128'(m_axis_tdest), 128'(s));
                chk("rr_data", m_axis_tdata, mk(s, 300 + r));
            end
        end
        tick();
        chk("rr_no_drops", 128'(drop_count), 128'(0));
        chk("rr_idle", 128'(m_axis_tvalid), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trace_stream_arbiter.md
# trace_stream_arbiter

Merges NUM_SRC non-backpressurable 128-bit trace-record streams onto one AXI-stream master with round-robin arbitration. Each source has a one-entry holding register. A record that arrives while its holding register is occupied is dropped and counted. The next record accepted from that source has overflow bit 31 set. Sits between the per-channel trace generators and the single host-bound trace FIFO/DMA stream.

## Interface

Parameters:

- NUM_SRC, 4, number of input streams (2..8)
- DATA_W, 128, record width; must be ≥32
- CNT_W, 16, per-source drop counter width
- SRC_W, $clog2(NUM_SRC), tdest width (derived)

Ports:

- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  reset, synchronous, active-low
- s_axis_tvalid  in  NUM_SRC  per-source record valid
- s_axis_tready  out  NUM_SRC  tied to all-ones; sources are never stalled
- s_axis_tdata  in  NUM_SRC*DATA_W  source i at [i*DATA_W +: DATA_W]
- m_axis_tvalid  out  1  output record valid
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  DATA_W  record; bit 31 is ORed with the overflow flag
- m_axis_tdest  out  SRC_W  source index of the current output record
- drop_count  out  NUM_SRC*CNT_W  saturating drop counters, source i at [i*CNT_W +: CNT_W]
- clear_counts  in  1  synchronous clear of all drop counters

## Operation

- Per source i, the holding register stores: full_i, data_i, ovf_i. Each source also has a sticky pend_i.
- **Capture.** The record is written when s_axis_tvalid[i] && (!full_i || drain_i), where drain_i means source i is granted this cycle.
  - On capture: ovf_i <= pend_i; pend_i <= 0; full_i <= 1.
- **Drop.** When s_axis_tvalid[i] && full_i && !drain_i:
  - The record is discarded.
  - pend_i <= 1.
  - drop_count_i increments, saturating at 2^CNT_W−1.
- **Drain without capture.** full_i <= 0.
- **Output register.** Loading is allowed when out_free = !m_axis_tvalid || m_axis_tready.
  - When out_free and any full_i, the round-robin arbiter grants the first full source after last_grant (wrapping).
  - The load sets: m_axis_tdata <= data_g with bit 31 = data_g[31] | ovf_g; m_axis_tdest <= g; m_axis_tvalid <= 1; last_grant <= g.
- When out_free and no source is full, m_axis_tvalid <= 0.
- AXI rule: while m_axis_tvalid && !m_axis_tready, tdata and tdest are held stable.
- **clear_counts** zeroes all counters. If an increment coincides, the clear wins and the increment is lost.
- **Reset values:**
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tdest=0
  - all full/ovf/pend=0, drop_count=0
  - last_grant=NUM_SRC−1, so source 0 has first priority
- Reset mid-transfer discards all held records without raising any flag.

## Timing

- Latency with an idle output: s_axis_tvalid in cycle t → holding full in t+1 → m_axis_tvalid high in t+2.
- Throughput: one output record per cycle while m_axis_tready=1.
- A single active source sustains one record/cycle with no drops, because drain and capture happen in the same cycle.
- With k active sources at full rate and m_axis_tready=1, each source gets a grant every k cycles. Its remaining records are dropped.
- Grant fairness: a continuously full source waits at most NUM_SRC−1 grants.
- Drop counting and pend updates take effect on the edge that ends the drop cycle.
- The flag lands on the next captured record, not on the held one.

## Structure

- Package trace_arb_pkg holds: OVF_BIT=31, the default DATA_W/CNT_W, and a typedef for a holding entry {full, ovf, data}.
- Sub-module rr_arbiter (NUM_SRC): inputs req vector and last_grant; outputs one-hot grant, grant index and any_grant. Purely combinational; the pointer register lives in the top.
- The top contains the holding registers, the counters and the output register. The generate loop runs over sources.

## Test plan

- Single source 0, data 0x…0001, tready=1 → m_axis_tvalid at t+2, tdata=0x…0001, tdest=0, bit 31=0.
- Source 1 sends 3 back-to-back records while tready=0 for 4 cycles → records 2 and 3 dropped, drop_count[1]=2. The held record 1 emerges unflagged. The next accepted record from source 1 has bit 31=1. A later record has bit 31=0.
- All 4 sources valid in the same cycle, tready=1 → output tdest order 0,1,2,3. Next round 0,1,2,3. No grant skipped.
- tready toggled 1/0 every cycle with 2 active sources → tdata/tdest unchanged while stalled; no record duplicated or lost beyond counted drops.
- CNT_W=4, force 20 drops on source 2 → drop_count[2] saturates at 15. clear_counts pulsed alongside a drop → count=0.
- aresetn low for 1 cycle while holding registers are full and m_axis_tvalid=1 → next cycle m_axis_tvalid=0, counters=0, first grant after reset goes to source 0, and no bit 31 set.
